// File: rtl/pim_conv_seq.sv
// Sequenced PIM convolution stage: issues one PIM request per (filter, channel),
// accumulates signed partial sums, then shifts, clamps and packs DEPTH results.
module pim_conv_seq #(
  parameter int KERNEL_SIZE = 5,
  parameter int CHANNEL     = 1,
  parameter int DEPTH       = 6,
  parameter int BIT_WIDTH   = 8,
  parameter int PSUM_WIDTH  = 16,
  parameter int ACC_WIDTH   = 20,
  parameter int OUT_WIDTH   = 8,
  parameter int SHIFT       = 4
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                start,
  input  logic                                                relu_en,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*CHANNEL*BIT_WIDTH-1:0] feature,
  output logic                                                busy,
  output logic                                                done,
  output logic [OUT_WIDTH*DEPTH-1:0]                          out,
  output logic                                                pim_req,
  output logic [(DEPTH > 1 ? $clog2(DEPTH) : 1)-1:0]          pim_filt,
  output logic [(CHANNEL > 1 ? $clog2(CHANNEL) : 1)-1:0]      pim_chan,
  output logic [KERNEL_SIZE*KERNEL_SIZE*BIT_WIDTH-1:0]        pim_data,
  input  logic                                                pim_rsp_valid,
  input  logic signed [PSUM_WIDTH-1:0]                        pim_rsp
);

  localparam int SLICE_W = KERNEL_SIZE * KERNEL_SIZE * BIT_WIDTH;
  localparam int FEAT_W  = SLICE_W * CHANNEL;
  localparam int FILT_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CHAN_W  = (CHANNEL > 1) ? $clog2(CHANNEL) : 1;

  localparam logic signed [ACC_WIDTH-1:0] RELU_MAX = ACC_WIDTH'((2 ** OUT_WIDTH) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX  = ACC_WIDTH'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN  = ACC_WIDTH'(-(2 ** (OUT_WIDTH - 1)));

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, POST, FIN} state_t;

  state_t                        state_q, state_d;
  logic [FEAT_W-1:0]             feature_q, feature_d;
  logic                          relu_q, relu_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [FILT_W-1:0]             filt_q, filt_d;
  logic [CHAN_W-1:0]             ch_q, ch_d;
  logic [OUT_WIDTH*DEPTH-1:0]    out_q, out_d;

  logic signed [ACC_WIDTH-1:0]   shifted;
  logic [OUT_WIDTH-1:0]          post_val;

  // Post-processing of the finished accumulator for the current filter.
  always_comb begin
    shifted = acc_q >>> SHIFT;
    if (relu_q) begin
      if (shifted[ACC_WIDTH-1])    post_val = '0;
      else if (shifted > RELU_MAX) post_val = '1;
      else                         post_val = shifted[OUT_WIDTH-1:0];
    end else begin
      if (shifted > SAT_MAX)       post_val = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      else if (shifted < SAT_MIN)  post_val = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      else                         post_val = shifted[OUT_WIDTH-1:0];
    end
  end

  always_comb begin
    pim_data = '0;
    for (int c = 0; c < CHANNEL; c++) begin
      if (ch_q == CHAN_W'(c)) pim_data = feature_q[c*SLICE_W +: SLICE_W];
    end
  end

  // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    feature_d = feature_q;
    relu_d    = relu_q;
    acc_d     = acc_q;
    filt_d    = filt_q;
    ch_d      = ch_q;
    out_d     = out_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          feature_d = feature;
          relu_d    = relu_en;
          acc_d     = '0;
          filt_d    = '0;
          ch_d      = '0;
          state_d   = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (pim_rsp_valid) begin
          acc_d = acc_q + {{(ACC_WIDTH-PSUM_WIDTH){pim_rsp[PSUM_WIDTH-1]}}, pim_rsp};
          if (ch_q == CHAN_W'(CHANNEL - 1)) begin
            state_d = POST;
          end else begin
            ch_d    = ch_q + CHAN_W'(1);
            state_d = ISSUE;
          end
        end
      end
      POST: begin
        for (int i = 0; i < DEPTH; i++) begin
          if (filt_q == FILT_W'(i)) out_d[i*OUT_WIDTH +: OUT_WIDTH] = post_val;
        end
        if (filt_q == FILT_W'(DEPTH - 1)) begin
          state_d = FIN;
        end else begin
          filt_d  = filt_q + FILT_W'(1);
          ch_d    = '0;
          acc_d   = '0;
          state_d = ISSUE;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the latched window is reset along with control so a reset leaves no stale data on pim_data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      feature_q <= '0;
      relu_q    <= 1'b0;
      acc_q     <= '0;
      filt_q    <= '0;
      ch_q      <= '0;
      out_q     <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      state_q   <= state_d;
      feature_q <= feature_d;
      relu_q    <= relu_d;
      acc_q     <= acc_d;
      filt_q    <= filt_d;
      ch_q      <= ch_d;
      out_q     <= out_d;
    end
  end

  assign busy     = (state_q == ISSUE) || (state_q == WAIT) || (state_q == POST);
  assign done     = (state_q == FIN);
  assign pim_req  = (state_q == ISSUE);
  assign pim_filt = filt_q;
  assign pim_chan = ch_q;
  assign out      = out_q;

endmodule

// File: tb/tb_pim_conv_seq.sv
// Bench for pim_conv_seq: a default instance (1 channel, 6 filters) and a
// 3-channel / 2-filter instance, driven by a bench-side PIM responder.
module tb_pim_conv_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: defaults
  logic         start_a, relu_a, busy_a, done_a, req_a, rspv_a;
  logic [199:0] feature_a, data_a;
  logic [47:0]  out_a;
  logic [2:0]   filt_a;
  logic [0:0]   chan_a;
  logic signed [15:0] rsp_a;

  // Instance B: CHANNEL=3, DEPTH=2
  logic         start_b, relu_b, busy_b, done_b, req_b, rspv_b;
  logic [599:0] feature_b;
  logic [199:0] data_b;
  logic [15:0]  out_b;
  logic [0:0]   filt_b;
  logic [1:0]   chan_b;
  logic signed [15:0] rsp_b;

  pim_conv_seq dut_a (
    .clk(clk), .rst(rst), .start(start_a), .relu_en(relu_a), .feature(feature_a),
    .busy(busy_a), .done(done_a), .out(out_a), .pim_req(req_a), .pim_filt(filt_a),
    .pim_chan(chan_a), .pim_data(data_a), .pim_rsp_valid(rspv_a), .pim_rsp(rsp_a)
  );

  pim_conv_seq #(.CHANNEL(3), .DEPTH(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .relu_en(relu_b), .feature(feature_b),
    .busy(busy_b), .done(done_b), .out(out_b), .pim_req(req_b), .pim_filt(filt_b),
    .pim_chan(chan_b), .pim_data(data_b), .pim_rsp_valid(rspv_b), .pim_rsp(rsp_b)
  );

  int rsp_tab[6];
  int tab_b[2][3];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [599:0] rand_bits();
    logic [607:0] r;
    for (int i = 0; i < 19; i++) r[i*32 +: 32] = $urandom;
    return r[599:0];
  endfunction

  // Reference: arithmetic shift of the channel sum, then clamp to the output range.
  function automatic logic [7:0] post_model(input int acc, input bit relu);
    int v;
    v = acc >>> 4;
    if (relu) begin
      if (v < 0) v = 0;
      else if (v > 255) v = 255;
    end else begin
      if (v > 127) v = 127;
      else if (v < -128) v = -128;
    end
    return v[7:0];
  endfunction

  function automatic int rand_psum();
    logic [15:0] r;
    r = 16'($urandom);
    return int'($signed(r));
  endfunction

  // Runs one convolution on instance A starting in an IDLE cycle (#1 after an edge).
  task automatic run_a(input bit relu, input int max_wait, input bit spurious,
                       input bit busy_start, input bit fin_start, input int abort_filt);
    logic [199:0] feat;
    logic [47:0]  exp_out;
    int cyc, reqs, countdown, cur_f;
    bit pending, abort_now;
    feat = 200'(rand_bits());
    start_a = 1'b1; relu_a = relu; feature_a = feat;
    @(posedge clk); #1;
    start_a = 1'b0; relu_a = ~relu; feature_a = 200'(rand_bits());
    reqs = 0; pending = 1'b0; abort_now = 1'b0; countdown = 0; cur_f = 0;
    for (cyc = 1; cyc <= 400; cyc++) begin
      if (done_a) break;
      if (abort_now) begin
        rst = 1'b0; #1;
        check("abort_busy", busy_a, 1'b0);
        check("abort_done", done_a, 1'b0);
        check("abort_req", req_a, 1'b0);
        check("abort_out", out_a, 48'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
          rspv_a = 1'b1; rsp_a = 16'($urandom);
          @(posedge clk); #1;
          check("abort_late_done", done_a, 1'b0);
          check("abort_late_busy", busy_a, 1'b0);
        end
        rspv_a = 1'b0;
        return;
      end
      check("busy_during_run", busy_a, 1'b1);
      if (busy_start && cyc == 3) begin
        start_a = 1'b1; feature_a = 200'(rand_bits());
      end else begin
        start_a = 1'b0;
      end
      rspv_a = 1'b0; rsp_a = 16'($urandom);
      if (pending && countdown == 0) begin
        rspv_a = 1'b1; rsp_a = 16'(rsp_tab[cur_f]); pending = 1'b0;
      end else if (pending) begin
        countdown--;
      end else if (spurious && req_a) begin
        rspv_a = 1'b1;
      end
      if (req_a) begin
        check("req_filt", filt_a, reqs);
        check("req_chan", chan_a, 1'b0);
        check("req_data", data_a, feat);
        if (reqs == abort_filt) abort_now = 1'b1;
        cur_f = reqs; reqs++; pending = 1'b1;
        countdown = int'($urandom_range(max_wait, 0));
      end
      @(posedge clk); #1;
    end
    start_a = 1'b0; rspv_a = 1'b0;
    check("done_reached", done_a, 1'b1);
    if (max_wait == 0) check("latency", cyc, 6 * (2 * 1 + 1) + 1);
    check("req_count", reqs, 6);
    check("fin_busy", busy_a, 1'b0);
    for (int f = 0; f < 6; f++) exp_out[f*8 +: 8] = post_model(rsp_tab[f], relu);
    check("out_at_done", out_a, exp_out);
    start_a = fin_start; feature_a = 200'(rand_bits());
    @(posedge clk); #1;
    start_a = 1'b0;
    check("idle_busy", busy_a, 1'b0);
    check("idle_done", done_a, 1'b0);
    check("out_held", out_a, exp_out);
  endtask

  // Zero-wait run on instance B; checks the (filter, channel) request order.
  task automatic run_b(input bit relu);
    logic [599:0] feat;
    logic [15:0]  exp_out;
    int cyc, r, pf, pc, acc;
    bit pending;
    feat = rand_bits();
    start_b = 1'b1; relu_b = relu; feature_b = feat;
    @(posedge clk); #1;
    start_b = 1'b0; relu_b = ~relu; feature_b = rand_bits();
    r = 0; pending = 1'b0; pf = 0; pc = 0;
    for (cyc = 1; cyc <= 400; cyc++) begin
      if (done_b) break;
      rspv_b = 1'b0; rsp_b = 16'($urandom);
      if (pending) begin
        rspv_b = 1'b1; rsp_b = 16'(tab_b[pf][pc]); pending = 1'b0;
      end
      if (req_b) begin
        pf = r / 3; pc = r % 3;
        check("b_req_filt", filt_b, pf);
        check("b_req_chan", chan_b, pc);
        check("b_req_data", data_b, feat[pc*200 +: 200]);
        r++; pending = 1'b1;
      end
      @(posedge clk); #1;
    end
    rspv_b = 1'b0;
    check("b_done_reached", done_b, 1'b1);
    check("b_latency", cyc, 2 * (2 * 3 + 1) + 1);
    check("b_req_count", r, 6);
    for (int f = 0; f < 2; f++) begin
      acc = tab_b[f][0] + tab_b[f][1] + tab_b[f][2];
      exp_out[f*8 +: 8] = post_model(acc, relu);
    end
    check("b_out", out_b, exp_out);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0;
    start_a = 1'b0; relu_a = 1'b0; feature_a = '0; rspv_a = 1'b0; rsp_a = '0;
    start_b = 1'b0; relu_b = 1'b0; feature_b = '0; rspv_b = 1'b0; rsp_b = '0;
    #2;
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_req", req_a, 1'b0);
    check("rst_filt", filt_a, 3'd0);
    check("rst_chan", chan_a, 1'b0);
    check("rst_out", out_a, 48'h0);
    check("rst_b_busy", busy_b, 1'b0);
    check("rst_b_out", out_b, 16'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    for (int f = 0; f < 6; f++) rsp_tab[f] = 16 * (f + 1);
    run_a(1'b0, 0, 1'b0, 1'b0, 1'b0, -1);
    check("ramp_out", out_a, 48'h060504030201);

    rsp_tab = '{-4096, 8000, -4096, 8000, 0, 17};
    run_a(1'b0, 0, 1'b0, 1'b0, 1'b0, -1);
    check("sat_signed", out_a, 48'h11_00_7f_80_7f_80 & 48'h01_00_7f_80_7f_80);
    run_a(1'b1, 0, 1'b0, 1'b0, 1'b0, -1);
    check("sat_relu", out_a, 48'h01_00_ff_00_ff_00);

    for (int it = 0; it < 4; it++) begin
      for (int f = 0; f < 6; f++) rsp_tab[f] = rand_psum();
      run_a(1'($urandom), 7, 1'b1, 1'b1, 1'b0, -1);
    end

    run_a(1'b0, 0, 1'b1, 1'b0, 1'b1, -1);
    run_a(1'b1, 0, 1'b0, 1'b0, 1'b0, -1);

    for (int f = 0; f < 6; f++) rsp_tab[f] = 16 * (f + 1);
    run_a(1'b0, 0, 1'b0, 1'b0, 1'b0, 3);
    run_a(1'b0, 0, 1'b0, 1'b0, 1'b0, -1);
    check("post_abort_out", out_a, 48'h060504030201);

    tab_b = '{'{100, -20, -16}, '{100, -20, -16}};
    run_b(1'b0);
    check("b_directed_out", out_b, 16'h0404);
    for (int f = 0; f < 2; f++)
      for (int c = 0; c < 3; c++) tab_b[f][c] = rand_psum();
    run_b(1'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
